// File: rtl/ysyx_24100029_mem_stage.sv
// ysyx_24100029_mem_stage
// Memory-access stage between EXU and WBU. It accepts one instruction at a
// time and runs at most one request/response transaction on the data-memory
// port for it. Results go into an output register that feeds WBU.
//
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   in_valid/in_ready            EXU handshake
//   Ex_result, store_data,       instruction fields from EXU
//   funct3, mem_ren, mem_wen,
//   side_in
//   valid_next/out_ready         WBU handshake
//   Ex_result_next, MEM_Rdata,   registered result toward WBU
//   mem_ren_next, mem_err,
//   side_next
//   req_*                        data-memory request channel
//   resp_*                       data-memory response channel
module ysyx_24100029_mem_stage #(
    parameter int SIDE_W = 43
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       Ex_result,
    input  logic [31:0]       store_data,
    input  logic [2:0]        funct3,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [SIDE_W-1:0] side_in,
    output logic              valid_next,
    input  logic              out_ready,
    output logic [31:0]       Ex_result_next,
    output logic [31:0]       MEM_Rdata,
    output logic              mem_ren_next,
    output logic              mem_err,
    output logic [SIDE_W-1:0] side_next,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_wen,
    output logic [31:0]       req_addr,
    output logic [31:0]       req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              resp_valid,
    input  logic [31:0]       resp_rdata,
    input  logic              resp_err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    // Byte enables for the access size before lane shifting.
    function automatic logic [3:0] size_strobe(input logic [2:0] f3);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = 4'b0001;
            2'b01:   s = 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        case (f3[1:0])
            2'b01:   m = off[0];
            2'b10:   m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Bring the addressed bytes down to bit 0 and extend per funct3.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'h000000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_t state_r;
    state_t state_n_s;

    // Request fields and the instruction context held during a transaction.
    logic              req_wen_r;
    logic [31:0]       req_addr_r;
    logic [31:0]       req_wdata_r;
    logic [3:0]        req_wstrb_r;
    logic [2:0]        funct3_r;
    logic [1:0]        offset_r;
    logic [31:0]       ex_hold_r;
    logic [SIDE_W-1:0] side_hold_r;
    logic              ren_hold_r;

    // Output register toward WBU.
    logic              valid_next_r;
    logic [31:0]       ex_next_r;
    logic [31:0]       rdata_next_r;
    logic              ren_next_r;
    logic              err_next_r;
    logic [SIDE_W-1:0] side_next_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              is_mem_s;
    logic              misalign_s;
    logic              start_txn_s;
    logic              resp_take_s;
    logic              out_wr_s;
    logic [31:0]       wr_ex_s;
    logic [31:0]       wr_rdata_s;
    logic              wr_ren_s;
    logic              wr_err_s;
    logic [SIDE_W-1:0] wr_side_s;

    assign in_ready_s  = (state_r == S_IDLE) & (~valid_next_r | out_ready);
    assign accept_s    = in_valid & in_ready_s;
    assign is_mem_s    = mem_ren | mem_wen;
    assign misalign_s  = is_mem_s & is_misaligned(funct3, Ex_result[1:0]);
    assign start_txn_s = accept_s & is_mem_s & ~misalign_s;
    assign resp_take_s = (state_r == S_WAIT_RESP) & resp_valid;
    // Non-memory and misaligned ops complete in IDLE without touching the bus.
    assign out_wr_s    = (accept_s & ~start_txn_s) | resp_take_s;

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_txn_s) state_n_s = S_REQ;
                else             state_n_s = S_IDLE;
            end
            S_REQ: begin
                if (req_ready) state_n_s = S_WAIT_RESP;
                else           state_n_s = S_REQ;
            end
            S_WAIT_RESP: begin
                if (resp_valid) state_n_s = S_DONE;
                else            state_n_s = S_WAIT_RESP;
            end
            S_DONE: begin
                if (~valid_next_r | out_ready) state_n_s = S_IDLE;
                else                           state_n_s = S_DONE;
            end
            default: state_n_s = S_IDLE;
        endcase
    end

    // Select what goes into the output register: a bus response or the
    // directly completed instruction from EXU.
    always_comb begin
        wr_ex_s    = Ex_result;
        wr_side_s  = side_in;
        wr_ren_s   = mem_ren;
        wr_err_s   = misalign_s;
        wr_rdata_s = 32'h0000_0000;
        if (resp_take_s) begin
            wr_ex_s   = ex_hold_r;
            wr_side_s = side_hold_r;
            wr_ren_s  = ren_hold_r;
            wr_err_s  = resp_err;
            if (ren_hold_r & ~resp_err) wr_rdata_s = load_extend(resp_rdata, offset_r, funct3_r);
            else                        wr_rdata_s = 32'h0000_0000;
        end else begin
            wr_rdata_s = 32'h0000_0000;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= S_IDLE;
        else        state_r <= state_n_s;
    end

    // Capture request fields and instruction context when a transaction starts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_wen_r   <= 1'b0;
            req_addr_r  <= 32'h0000_0000;
            req_wdata_r <= 32'h0000_0000;
            req_wstrb_r <= 4'b0000;
            funct3_r    <= 3'b000;
            offset_r    <= 2'b00;
            ex_hold_r   <= 32'h0000_0000;
            side_hold_r <= {SIDE_W{1'b0}};
            ren_hold_r  <= 1'b0;
        end else if (start_txn_s) begin
            req_wen_r   <= mem_wen;
            req_addr_r  <= {Ex_result[31:2], 2'b00};
            req_wdata_r <= store_data << {Ex_result[1:0], 3'b000};
            req_wstrb_r <= mem_wen ? (size_strobe(funct3) << Ex_result[1:0]) : 4'b0000;
            funct3_r    <= funct3;
            offset_r    <= Ex_result[1:0];
            ex_hold_r   <= Ex_result;
            side_hold_r <= side_in;
            ren_hold_r  <= mem_ren;
        end
    end

    // Output register; valid drops on a WBU transfer unless refilled that cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_next_r <= 1'b0;
            ex_next_r    <= 32'h0000_0000;
            rdata_next_r <= 32'h0000_0000;
            ren_next_r   <= 1'b0;
            err_next_r   <= 1'b0;
            side_next_r  <= {SIDE_W{1'b0}};
        end else if (out_wr_s) begin
            valid_next_r <= 1'b1;
            ex_next_r    <= wr_ex_s;
            rdata_next_r <= wr_rdata_s;
            ren_next_r   <= wr_ren_s;
            err_next_r   <= wr_err_s;
            side_next_r  <= wr_side_s;
        end else if (out_ready) begin
            valid_next_r <= 1'b0;
        end
    end

    assign in_ready       = in_ready_s;
    assign valid_next     = valid_next_r;
    assign Ex_result_next = ex_next_r;
    assign MEM_Rdata      = rdata_next_r;
    assign mem_ren_next   = ren_next_r;
    assign mem_err        = err_next_r;
    assign side_next      = side_next_r;
    assign req_valid      = (state_r == S_REQ);
    assign req_wen        = req_wen_r;
    assign req_addr       = req_addr_r;
    assign req_wdata      = req_wdata_r;
    assign req_wstrb      = req_wstrb_r;

endmodule

// File: tb/tb_ysyx_24100029_mem_stage.sv
module tb_ysyx_24100029_mem_stage;

    localparam int SIDE_W = 43;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       Ex_result;
    logic [31:0]       store_data;
    logic [2:0]        funct3;
    logic              mem_ren;
    logic              mem_wen;
    logic [SIDE_W-1:0] side_in;
    logic              valid_next;
    logic              out_ready;
    logic [31:0]       Ex_result_next;
    logic [31:0]       MEM_Rdata;
    logic              mem_ren_next;
    logic              mem_err;
    logic [SIDE_W-1:0] side_next;
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    int checks_r = 0;
    int errors_r = 0;

    ysyx_24100029_mem_stage #(.SIDE_W(SIDE_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .Ex_result      (Ex_result),
        .store_data     (store_data),
        .funct3         (funct3),
        .mem_ren        (mem_ren),
        .mem_wen        (mem_wen),
        .side_in        (side_in),
        .valid_next     (valid_next),
        .out_ready      (out_ready),
        .Ex_result_next (Ex_result_next),
        .MEM_Rdata      (MEM_Rdata),
        .mem_ren_next   (mem_ren_next),
        .mem_err        (mem_err),
        .side_next      (side_next),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wen        (req_wen),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full load/store with req_ready and resp_valid asserted at the earliest cycle.
    task automatic mem_op(input string tag, input logic [31:0] ex, input logic [31:0] sd,
                          input logic [2:0] f3, input logic ren, input logic wen,
                          input logic [31:0] rdata, input logic [31:0] e_addr,
                          input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                          input logic [31:0] e_rdata);
        @(negedge clock);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; Ex_result = ex; store_data = sd; funct3 = f3;
        mem_ren = ren; mem_wen = wen; side_in = 43'h155;
        @(negedge clock);
        in_valid = 1'b0;
        check({tag, "_req_valid"}, 64'(req_valid), 64'd1);
        check({tag, "_req_wen"},   64'(req_wen),   64'(wen));
        check({tag, "_req_addr"},  64'(req_addr),  64'(e_addr));
        check({tag, "_req_wdata"}, 64'(req_wdata), 64'(e_wdata));
        check({tag, "_req_wstrb"}, 64'(req_wstrb), 64'(e_wstrb));
        req_ready = 1'b1;
        @(negedge clock);
        req_ready = 1'b0;
        check({tag, "_req_drop"}, 64'(req_valid), 64'd0);
        check({tag, "_no_early"}, 64'(valid_next), 64'd0);
        resp_valid = 1'b1; resp_rdata = rdata; resp_err = 1'b0;
        @(negedge clock);
        resp_valid = 1'b0;
        check({tag, "_valid"},  64'(valid_next),     64'd1);
        check({tag, "_rdata"},  64'(MEM_Rdata),      64'(e_rdata));
        check({tag, "_err"},    64'(mem_err),        64'd0);
        check({tag, "_ren"},    64'(mem_ren_next),   64'(ren));
        check({tag, "_ex"},     64'(Ex_result_next), 64'(ex));
        check({tag, "_side"},   64'(side_next),      64'h155);
        @(negedge clock);
        check({tag, "_drain"}, 64'(valid_next), 64'd0);
    endtask

    logic [31:0] exv [4];

    initial begin
        exv[0] = 32'h0000_0011; exv[1] = 32'hDEAD_BEEF;
        exv[2] = 32'h8000_0004; exv[3] = 32'h1234_5678;
        reset = 1'b0; in_valid = 1'b0; Ex_result = 32'h0; store_data = 32'h0;
        funct3 = 3'b000; mem_ren = 1'b0; mem_wen = 1'b0; side_in = 43'h0;
        out_ready = 1'b1; req_ready = 1'b0; resp_valid = 1'b0;
        resp_rdata = 32'h0; resp_err = 1'b0;

        // Reset state.
        @(negedge clock);
        @(negedge clock);
        check("rst_valid",  64'(valid_next),     64'd0);
        check("rst_reqv",   64'(req_valid),      64'd0);
        check("rst_wen",    64'(req_wen),        64'd0);
        check("rst_err",    64'(mem_err),        64'd0);
        check("rst_ren",    64'(mem_ren_next),   64'd0);
        check("rst_ex",     64'(Ex_result_next), 64'd0);
        check("rst_rdata",  64'(MEM_Rdata),      64'd0);
        check("rst_side",   64'(side_next),      64'd0);
        check("rst_addr",   64'(req_addr),       64'd0);
        check("rst_wdata",  64'(req_wdata),      64'd0);
        check("rst_wstrb",  64'(req_wstrb),      64'd0);
        reset = 1'b1;

        // Back-to-back non-memory ops.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i > 0) begin
                check("nm_valid", 64'(valid_next),     64'd1);
                check("nm_ex",    64'(Ex_result_next), 64'(exv[i-1]));
                check("nm_side",  64'(side_next),      64'(43'h1A5 + 43'(i - 1)));
                check("nm_ren",   64'(mem_ren_next),   64'd0);
            end
            if (i < 4) begin
                check("nm_in_ready", 64'(in_ready), 64'd1);
                in_valid = 1'b1; Ex_result = exv[i]; side_in = 43'h1A5 + 43'(i);
                mem_ren = 1'b0; mem_wen = 1'b0; funct3 = 3'b010;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clock);
        check("nm_drain", 64'(valid_next), 64'd0);

        mem_op("lb",  32'h8000_0003, 32'h0, 3'b000, 1'b1, 1'b0, 32'h80FF_1234,
               32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80);
        mem_op("lbu", 32'h8000_0003, 32'h0, 3'b100, 1'b1, 1'b0, 32'h80FF_1234,
               32'h8000_0000, 32'h0, 4'b0000, 32'h0000_0080);
        mem_op("sh",  32'h8000_0002, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 32'h5555_5555,
               32'h8000_0000, 32'hABCD_0000, 4'b1100, 32'h0);
        mem_op("lh",  32'h8000_0006, 32'h0, 3'b001, 1'b1, 1'b0, 32'h80FF_1234,
               32'h8000_0004, 32'h0, 4'b0000, 32'hFFFF_80FF);
        mem_op("lhu", 32'h8000_0006, 32'h0, 3'b101, 1'b1, 1'b0, 32'h80FF_1234,
               32'h8000_0004, 32'h0, 4'b0000, 32'h0000_80FF);
        mem_op("lw",  32'h8000_0008, 32'h0, 3'b010, 1'b1, 1'b0, 32'h1234_5678,
               32'h8000_0008, 32'h0, 4'b0000, 32'h1234_5678);
        mem_op("sb",  32'h8000_0001, 32'h0000_00A5, 3'b000, 1'b0, 1'b1, 32'h0,
               32'h8000_0000, 32'h0000_A500, 4'b0010, 32'h0);

        // Misaligned word load: no bus request, error result next cycle.
        @(negedge clock);
        in_valid = 1'b1; Ex_result = 32'h8000_0001; funct3 = 3'b010;
        mem_ren = 1'b1; mem_wen = 1'b0;
        @(negedge clock);
        in_valid = 1'b0; mem_ren = 1'b0;
        check("mis_reqv",  64'(req_valid),      64'd0);
        check("mis_valid", 64'(valid_next),     64'd1);
        check("mis_err",   64'(mem_err),        64'd1);
        check("mis_rdata", 64'(MEM_Rdata),      64'd0);
        check("mis_ex",    64'(Ex_result_next), 64'h8000_0001);
        @(negedge clock);
        check("mis_reqv2", 64'(req_valid),  64'd0);
        check("mis_drain", 64'(valid_next), 64'd0);

        // Stalled store request, then bus error with WBU back-pressure.
        @(negedge clock);
        check("st_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; Ex_result = 32'h8000_0010; store_data = 32'h1122_3344;
        funct3 = 3'b010; mem_ren = 1'b0; mem_wen = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b0; mem_wen = 1'b0; store_data = 32'h0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            check("st_reqv",  64'(req_valid), 64'd1);
            check("st_addr",  64'(req_addr),  64'h8000_0010);
            check("st_wdata", 64'(req_wdata), 64'h1122_3344);
            check("st_wstrb", 64'(req_wstrb), 64'hF);
            check("st_wen",   64'(req_wen),   64'd1);
        end
        req_ready = 1'b1;
        @(negedge clock);
        req_ready = 1'b0;
        resp_valid = 1'b1; resp_err = 1'b1; resp_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        resp_valid = 1'b0; resp_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            check("be_valid",    64'(valid_next),     64'd1);
            check("be_err",      64'(mem_err),        64'd1);
            check("be_rdata",    64'(MEM_Rdata),      64'd0);
            check("be_ex",       64'(Ex_result_next), 64'h8000_0010);
            check("be_in_ready", 64'(in_ready),       64'd0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("be_drain",     64'(valid_next), 64'd0);
        check("be_in_ready2", 64'(in_ready),   64'd1);

        // Reset during WAIT_RESP.
        @(negedge clock);
        in_valid = 1'b1; Ex_result = 32'h8000_0020; funct3 = 3'b010;
        mem_ren = 1'b1; mem_wen = 1'b0; side_in = 43'h7;
        @(negedge clock);
        in_valid = 1'b0; mem_ren = 1'b0;
        check("rw_reqv", 64'(req_valid), 64'd1);
        req_ready = 1'b1;
        @(negedge clock);
        req_ready = 1'b0;
        check("rw_addr_pre", 64'(req_addr), 64'h8000_0020);
        reset = 1'b0;
        #1;
        check("rw_reqv0",  64'(req_valid),      64'd0);
        check("rw_addr0",  64'(req_addr),       64'd0);
        check("rw_valid0", 64'(valid_next),     64'd0);
        check("rw_ex0",    64'(Ex_result_next), 64'd0);
        check("rw_err0",   64'(mem_err),        64'd0);
        check("rw_side0",  64'(side_next),      64'd0);
        @(negedge clock);
        reset = 1'b1;
        resp_valid = 1'b1; resp_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        resp_valid = 1'b0;
        check("rw_late_valid", 64'(valid_next), 64'd0);
        check("rw_late_reqv",  64'(req_valid),  64'd0);
        check("rw_in_ready",   64'(in_ready),   64'd1);
        in_valid = 1'b1; Ex_result = 32'h0000_0ABC; side_in = 43'h3C;
        @(negedge clock);
        in_valid = 1'b0;
        check("rw_next_valid", 64'(valid_next),     64'd1);
        check("rw_next_ex",    64'(Ex_result_next), 64'h0000_0ABC);
        check("rw_next_side",  64'(side_next),      64'h3C);
        check("rw_next_rdata", 64'(MEM_Rdata),      64'd0);

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_24100029_mem_stage.md
# ysyx_24100029_mem_stage
Memory-access stage of the ysyx_24100029 in-order pipeline. It sits between EXU and WBU and accepts one instruction at a time over a valid/ready handshake. For loads and stores it runs a single transaction on a simple request/response data-memory port, with byte-lane alignment, write strobes and load sign/zero extension. It holds the result in an output register that feeds WBU's MEM_Rdata, Ex_result, mem_ren and sideband inputs.
## Interface
- SIDE_W, 43: width of opaque sideband passed through unchanged, packed {rd_value[31:0], rd[4:0], csr_wen[3:0], R_wen, jump_flag}.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; assertion (0) immediately clears all state.
- in_valid  in  1  EXU presents an instruction.
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready at a rising edge.
- Ex_result  in  32  ALU result; effective address for loads/stores.
- store_data  in  32  rs2 value for stores.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_ren  in  1  instruction is a load.
- mem_wen  in  1  instruction is a store; never both with mem_ren.
- side_in  in  SIDE_W  sideband from EXU.
- valid_next  out  1  result valid toward WBU.
- out_ready  in  1  WBU accepts; transfer when valid_next & out_ready.
- Ex_result_next  out  32  registered Ex_result.
- MEM_Rdata  out  32  aligned, extended load data; 0 for non-loads.
- mem_ren_next  out  1  registered mem_ren.
- mem_err  out  1  misaligned access or bus error response.
- side_next  out  SIDE_W  registered sideband.
- req_valid  out  1  memory request valid.
- req_ready  in  1  memory accepts request.
- req_wen  out  1  1 = write, 0 = read.
- req_addr  out  32  word-aligned address {Ex_result[31:2], 2'b00}.
- req_wdata  out  32  store_data shifted left by 8*Ex_result[1:0].
- req_wstrb  out  4  byte enables: B 4'b0001, H 4'b0011, W 4'b1111, shifted left by Ex_result[1:0]; 0 on reads.
- resp_valid  in  1  response present; the stage accepts it in any cycle of WAIT_RESP (no back-pressure).
- resp_rdata  in  32  read data, whole word.
- resp_err  in  1  bus error; qualifies resp_valid.
## Operation
- FSM states: IDLE, REQ, WAIT_RESP, DONE. Reset state IDLE.
- in_ready = (state==IDLE) & (~valid_next | out_ready).
- IDLE, accept non-memory op: latch Ex_result, side_in and mem_ren=0 into the output register, MEM_Rdata=0, mem_err=0, set valid_next; stay in IDLE.
- IDLE, accept aligned load/store: latch the request fields and go to REQ.
- Alignment: H requires Ex_result[0]=0; W requires Ex_result[1:0]=0.
- Misaligned load/store: no bus request; the result is output as for a non-memory op, with mem_err=1 and MEM_Rdata=0.
- REQ: req_valid=1 with constant address, data and strobe; on req_ready go to WAIT_RESP.
- WAIT_RESP: on resp_valid, write the output register and set valid_next, then go to DONE.
  - Load data: shift resp_rdata right by 8*offset, sign-extend (B/H) or zero-extend (BU/HU).
  - Stores: MEM_Rdata=0.
  - resp_err=1: mem_err=1, MEM_Rdata=0.
- DONE: when ~valid_next | out_ready, go to IDLE. The output register is never overwritten while valid_next & ~out_ready.
- valid_next clears on a WBU transfer unless a new result is written in the same cycle.
## Timing
- Reset values: valid_next 0, req_valid 0, req_wen 0, mem_err 0, mem_ren_next 0; all data outputs 0; state IDLE.
- Non-memory op: accepted at edge N, valid_next high from N+1. Back-to-back throughput is 1 per cycle when out_ready=1.
- Load/store, minimum latency:
  - accepted at edge N; req_valid from N+1;
  - with req_ready=1, WAIT_RESP from N+2;
  - with resp_valid in that cycle, valid_next from N+3.
  - The next accept is possible in cycle N+4 when out_ready=1.
- req_valid holds, with all req_* fields stable, until the req_ready handshake.
- Reset asserted mid-transaction: the FSM returns to IDLE and the request drops. A late resp_valid seen in IDLE is ignored.
## Test plan
- Non-memory stream of 4 ops, out_ready=1 → valid_next on 4 consecutive cycles; Ex_result_next and side_next match the inputs in order.
- LB at 0x80000003, resp_rdata 0x80FF_1234 → req_addr 0x80000000, MEM_Rdata 0xFFFF_FF80; the same access as LBU gives 0x0000_0080.
- SH at 0x80000002, store_data 0x0000_ABCD → req_wen=1, req_wstrb 4'b1100, req_wdata 0xABCD_0000; valid_next 1 cycle after resp_valid.
- LW at 0x80000001 → no req_valid; valid_next next cycle with mem_err=1, MEM_Rdata 0.
- req_ready held low 5 cycles, then resp_err=1 → req_* stable for all 5 cycles; mem_err=1; out_ready low 3 cycles keeps outputs stable and in_ready=0.
- reset pulled low during WAIT_RESP → all outputs 0 immediately; a following resp_valid is ignored; the next op is accepted normally.
